// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default parameters for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CPU  = 2'd1,
      DMA  = 2'd2
   } owner_e;

   localparam int DEF_MEM_LAT    = 1;
   localparam int DEF_STARVE_MAX = 8;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of lost DMA arbitrations; fire flags the limit.
module arb_starve_ctr
#(
   parameter int MAX = 8
)(
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic fire
);

   localparam int W = (MAX > 1) ? $clog2(MAX + 1) : 1;
   localparam logic [W-1:0] LIMIT = W'(MAX);
   localparam logic [W-1:0] ONE   = W'(1);

   logic [W-1:0] cnt_r;

   // Count losses, clear on a DMA grant, hold at the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (inc && (cnt_r != LIMIT)) begin
         cnt_r <= cnt_r + ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign fire = (cnt_r == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU MEM stage and a DMA master.
// Defining DMEM_ARB_STARVE_GUARD_EN adds a starvation guard that forces a DMA grant.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit SINGLE_CYCLE = (MEM_LAT == 1);

   arb_state_e       state_r, state_s;
   owner_e           owner_r, owner_s;
   owner_e           grant_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             cpu_req_s;
   logic             done_s;
   logic             starve_fire_s;

   assign cpu_req_s = cpu_rd | cpu_wr;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   logic starve_inc_s;
   logic starve_clr_s;

   // Only ARB cycles are real arbitration decisions; HOLD cycles do not count.
   assign starve_inc_s = (state_r == ARB) & dma_req & (grant_s != DMA);
   assign starve_clr_s = (state_r == ARB) & (grant_s == DMA);

   arb_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (starve_inc_s),
      .clr   (starve_clr_s),
      .fire  (starve_fire_s)
   );
`else
   assign starve_fire_s = 1'b0;
`endif

   // State, owner and hold counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ARB;
         owner_r <= NONE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         cnt_r   <= cnt_s;
      end
   end

   // Grant decision, completion detect and next-state logic.
   always_comb begin
      grant_s = NONE;
      done_s  = 1'b0;
      state_s = state_r;
      owner_s = owner_r;
      cnt_s   = cnt_r;
      case (state_r)
         ARB: begin
            if (dma_req && (!cpu_req_s || starve_fire_s)) begin
               grant_s = DMA;
            end else if (cpu_req_s) begin
               grant_s = CPU;
            end else begin
               grant_s = NONE;
            end
            if ((grant_s != NONE) && !SINGLE_CYCLE) begin
               state_s = HOLD;
               owner_s = grant_s;
               cnt_s   = CNT_LOAD;
            end else begin
               state_s = ARB;
               owner_s = NONE;
               cnt_s   = '0;
            end
            done_s = SINGLE_CYCLE && (grant_s != NONE);
         end
         HOLD: begin
            grant_s = owner_r;
            if (cnt_r == CNT_ONE) begin
               done_s  = 1'b1;
               state_s = ARB;
               owner_s = NONE;
               cnt_s   = '0;
            end else begin
               done_s  = 1'b0;
               cnt_s   = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_s = ARB;
            owner_s = NONE;
            cnt_s   = '0;
         end
      endcase
   end

   // Bus steering and requester responses; everything is quiet while reset is high.
   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_rdata = '0;
      cpu_stall = 1'b0;
      dma_rdata = '0;
      dma_ack   = 1'b0;
      if (reset) begin
         mem_rd    = 1'b0;
         mem_wr    = 1'b0;
         cpu_stall = 1'b0;
         dma_ack   = 1'b0;
      end else begin
         case (grant_s)
            CPU: begin
               // A simultaneous read and write is executed as a write.
               mem_rd    = cpu_rd & ~cpu_wr;
               mem_wr    = cpu_wr & done_s;
               mem_addr  = cpu_addr;
               mem_wdata = cpu_wdata;
               cpu_rdata = done_s ? mem_rdata : '0;
            end
            DMA: begin
               mem_rd    = ~dma_we;
               mem_wr    = dma_we & done_s;
               mem_addr  = dma_addr;
               mem_wdata = dma_wdata;
               dma_rdata = done_s ? mem_rdata : '0;
               dma_ack   = done_s;
            end
            default: begin
               mem_rd = 1'b0;
               mem_wr = 1'b0;
            end
         endcase
         cpu_stall = cpu_req_s & ~((grant_s == CPU) & done_s);
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors on a single-cycle instance (starve limit 4) and
// hand-written multi-cycle sequences on a three-cycle instance.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct {
      logic [31:0] cpu_rdata;
      logic        cpu_stall;
      logic [31:0] dma_rdata;
      logic        dma_ack;
      logic        mem_rd;
      logic        mem_wr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        chk_bus;
   } exp_t;

   typedef struct {
      logic        cpu_rd;
      logic        cpu_wr;
      logic [31:0] cpu_addr;
      logic [31:0] cpu_wdata;
      logic        dma_req;
      logic        dma_we;
      logic [31:0] dma_addr;
      logic [31:0] dma_wdata;
      logic [31:0] mem_rdata;
      exp_t        e;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        a_cpu_rd = 1'b0, a_cpu_wr = 1'b0, a_dma_req = 1'b0, a_dma_we = 1'b0;
   logic [31:0] a_cpu_addr = 32'h0, a_cpu_wdata = 32'h0, a_dma_addr = 32'h0, a_dma_wdata = 32'h0;
   logic [31:0] a_mem_rdata = 32'h0;
   logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata;
   logic        a_cpu_stall, a_dma_ack, a_mem_rd, a_mem_wr;

   logic        b_cpu_rd = 1'b0, b_cpu_wr = 1'b0, b_dma_req = 1'b0, b_dma_we = 1'b0;
   logic [31:0] b_cpu_addr = 32'h0, b_cpu_wdata = 32'h0, b_dma_addr = 32'h0, b_dma_wdata = 32'h0;
   logic [31:0] b_mem_rdata = 32'h0;
   logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata;
   logic        b_cpu_stall, b_dma_ack, b_mem_rd, b_mem_wr;

   int n_vec  = 0;
   int n_miss = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
      .clk(clk), .reset(reset),
      .cpu_rd(a_cpu_rd), .cpu_wr(a_cpu_wr), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
      .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
      .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
      .dma_rdata(a_dma_rdata), .dma_ack(a_dma_ack),
      .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(8)) u_lat3 (
      .clk(clk), .reset(reset),
      .cpu_rd(b_cpu_rd), .cpu_wr(b_cpu_wr), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
      .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
      .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
      .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata)
   );

   function automatic exp_t ex(input logic [31:0] crd, input logic stl, input logic [31:0] drd,
                               input logic ack, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wd, input logic chk);
      exp_t r;
      r.cpu_rdata = crd; r.cpu_stall = stl; r.dma_rdata = drd; r.dma_ack = ack;
      r.mem_rd = rd; r.mem_wr = wr; r.mem_addr = addr; r.mem_wdata = wd; r.chk_bus = chk;
      return r;
   endfunction

   task automatic cmp(input string nm, input exp_t e, input exp_t a);
      n_vec++;
      if (a.cpu_rdata !== e.cpu_rdata) begin
         n_miss++; $display("FAIL %s cpu_rdata got %h want %h", nm, a.cpu_rdata, e.cpu_rdata);
      end
      if (a.cpu_stall !== e.cpu_stall) begin
         n_miss++; $display("FAIL %s cpu_stall got %b want %b", nm, a.cpu_stall, e.cpu_stall);
      end
      if (a.dma_rdata !== e.dma_rdata) begin
         n_miss++; $display("FAIL %s dma_rdata got %h want %h", nm, a.dma_rdata, e.dma_rdata);
      end
      if (a.dma_ack !== e.dma_ack) begin
         n_miss++; $display("FAIL %s dma_ack got %b want %b", nm, a.dma_ack, e.dma_ack);
      end
      if (a.mem_rd !== e.mem_rd) begin
         n_miss++; $display("FAIL %s mem_rd got %b want %b", nm, a.mem_rd, e.mem_rd);
      end
      if (a.mem_wr !== e.mem_wr) begin
         n_miss++; $display("FAIL %s mem_wr got %b want %b", nm, a.mem_wr, e.mem_wr);
      end
      if (e.chk_bus) begin
         if (a.mem_addr !== e.mem_addr) begin
            n_miss++; $display("FAIL %s mem_addr got %h want %h", nm, a.mem_addr, e.mem_addr);
         end
         if (a.mem_wdata !== e.mem_wdata) begin
            n_miss++; $display("FAIL %s mem_wdata got %h want %h", nm, a.mem_wdata, e.mem_wdata);
         end
      end
   endtask

   task automatic chk_a(input string nm, input exp_t e);
      cmp(nm, e, ex(a_cpu_rdata, a_cpu_stall, a_dma_rdata, a_dma_ack, a_mem_rd, a_mem_wr,
                    a_mem_addr, a_mem_wdata, 1'b1));
   endtask

   task automatic chk_b(input string nm, input exp_t e);
      cmp(nm, e, ex(b_cpu_rdata, b_cpu_stall, b_dma_rdata, b_dma_ack, b_mem_rd, b_mem_wr,
                    b_mem_addr, b_mem_wdata, 1'b1));
   endtask

   task automatic a_in(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic dq, input logic dwe, input logic [31:0] daddr,
                       input logic [31:0] dwd, input logic [31:0] mrd);
      a_cpu_rd = rd; a_cpu_wr = wr; a_cpu_addr = addr; a_cpu_wdata = wd;
      a_dma_req = dq; a_dma_we = dwe; a_dma_addr = daddr; a_dma_wdata = dwd; a_mem_rdata = mrd;
   endtask

   task automatic b_in(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic dq, input logic dwe, input logic [31:0] daddr,
                       input logic [31:0] dwd, input logic [31:0] mrd);
      b_cpu_rd = rd; b_cpu_wr = wr; b_cpu_addr = addr; b_cpu_wdata = wd;
      b_dma_req = dq; b_dma_we = dwe; b_dma_addr = daddr; b_dma_wdata = dwd; b_mem_rdata = mrd;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic b_step(input string nm, input exp_t e);
      #3;
      chk_b(nm, e);
      cyc();
   endtask

   vec_t  tbl [10];
   exp_t  z;
   exp_t  zb;
   logic  ack_i;
   logic [31:0] mr;

   initial begin
      z  = ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      zb = ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

      tbl[0] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5555_5555, z};
      tbl[1] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF,
                 ex(32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1)};
      tbl[2] = '{1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                 ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b1)};
      tbl[3] = '{1'b1, 1'b1, 32'h24, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                 ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h24, 32'h0BAD_F00D, 1'b1)};
      tbl[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D,
                 ex(32'h0, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1)};
      tbl[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h600D_D00D, 32'h0,
                 ex(32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h44, 32'h600D_D00D, 1'b1)};
      tbl[6] = '{1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b1, 32'h60, 32'h7777_8888, 32'h1357_2468,
                 ex(32'h1357_2468, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1)};
      tbl[7] = '{1'b0, 1'b1, 32'h54, 32'h9999_0000, 1'b1, 1'b0, 32'h64, 32'h0, 32'h0,
                 ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h54, 32'h9999_0000, 1'b1)};
      tbl[8] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h68, 32'h0, 32'h2468_ACE0,
                 ex(32'h0, 1'b0, 32'h2468_ACE0, 1'b1, 1'b1, 1'b0, 32'h68, 32'h0, 1'b1)};
      tbl[9] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0001, z};

      // Reset with requests pending: everything must stay quiet.
      a_in(1'b1, 1'b1, 32'h1, 32'h2, 1'b1, 1'b1, 32'h3, 32'h4, 32'hFFFF_FFFF);
      b_in(1'b1, 1'b1, 32'h1, 32'h2, 1'b1, 1'b1, 32'h3, 32'h4, 32'hFFFF_FFFF);
      cyc();
      #3;
      chk_a("reset_lat1", zb);
      chk_b("reset_lat3", zb);
      cyc();
      a_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      b_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      reset = 1'b0;
      cyc();

      for (int i = 0; i < 10; i++) begin
         a_in(tbl[i].cpu_rd, tbl[i].cpu_wr, tbl[i].cpu_addr, tbl[i].cpu_wdata, tbl[i].dma_req,
              tbl[i].dma_we, tbl[i].dma_addr, tbl[i].dma_wdata, tbl[i].mem_rdata);
         #3;
         chk_a($sformatf("tbl%0d", i), tbl[i].e);
         cyc();
      end

      // Continuous CPU reads against a waiting DMA read.
      for (int i = 0; i < 10; i++) begin
         mr = 32'h7000_0000 + 32'(i);
         a_in(1'b1, 1'b0, 32'h70, 32'h0, GUARD ? (i <= 4) : 1'b1, 1'b0, 32'h80, 32'h0, mr);
         ack_i = GUARD && (i == 4);
         #3;
         if (ack_i) chk_a($sformatf("starve%0d", i),
                          ex(32'h0, 1'b1, mr, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1));
         else       chk_a($sformatf("starve%0d", i),
                          ex(mr, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h70, 32'h0, 1'b1));
         cyc();
      end
      a_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

      // Collision on the three-cycle instance: CPU write first, then the DMA read.
      b_in(1'b0, 1'b1, 32'h100, 32'hAAAA_0001, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0);
      b_step("coll0", ex(32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'hAAAA_0001, 1'b1));
      b_step("coll1", ex(32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'hAAAA_0001, 1'b1));
      b_step("coll2", ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100, 32'hAAAA_0001, 1'b1));
      b_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h1111_2222);
      b_step("coll3", ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1));
      b_step("coll4", ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1));
      b_step("coll5", ex(32'h0, 1'b0, 32'h1111_2222, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1));
      b_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1111_2222);
      b_step("coll6", z);

      // DMA read already holding the port when a CPU read arrives.
      b_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h3333_0000);
      b_step("own0", ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1));
      b_in(1'b1, 1'b0, 32'h310, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h3333_0000);
      b_step("own1", ex(32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1));
      b_step("own2", ex(32'h0, 1'b1, 32'h3333_0000, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1));
      b_in(1'b1, 1'b0, 32'h310, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4444_0000);
      b_step("own3", ex(32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h310, 32'h0, 1'b1));
      b_step("own4", ex(32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h310, 32'h0, 1'b1));
      b_step("own5", ex(32'h4444_0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h310, 32'h0, 1'b1));
      b_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      b_step("own6", z);

      // Reset on the second cycle of a DMA write abandons it.
      b_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h400, 32'hBEEF_0001, 32'h0);
      b_step("rst0", ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h400, 32'hBEEF_0001, 1'b1));
      reset = 1'b1;
      b_step("rst1", zb);
      reset = 1'b0;
      b_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      b_step("rst2", zb);
      b_in(1'b1, 1'b0, 32'h410, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5555_AAAA);
      b_step("rst3", ex(32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h410, 32'h0, 1'b1));
      b_step("rst4", ex(32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h410, 32'h0, 1'b1));
      b_step("rst5", ex(32'h5555_AAAA, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h410, 32'h0, 1'b1));
      b_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      b_step("rst6", z);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory/bus port between the pipeline's MEM stage (CPU) and a DMA/loader master. The CPU has priority by default. Every access occupies the memory for a fixed number of cycles, and a CPU request that is not served drives `cpu_stall` back to the hazard logic, which freezes PC, IF/ID, ID/EX and EX/MEM. The block sits between the EX/MEM register outputs and the bus, replacing the direct CPU-to-bus connection.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 1, cycles per memory access; must be ≥1.
- `STARVE_MAX`, 8, waiting-DMA cycles before a forced DMA grant (only with guard enabled).

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_rd` in 1: CPU read request (EX/MEM Mem_rd).
- `cpu_wr` in 1: CPU write request (EX/MEM Mem_wr).
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_rdata` out DATA_W: read data to MEM/WB, valid in the CPU completion cycle.
- `cpu_stall` out 1: CPU request pending and not completing this cycle.
- `dma_req` in 1: DMA request; held with its payload until acked.
- `dma_we` in 1: DMA request is a write.
- `dma_addr` in ADDR_W: DMA address.
- `dma_wdata` in DATA_W: DMA write data.
- `dma_rdata` out DATA_W: DMA read data, valid while `dma_ack` is high.
- `dma_ack` out 1: one-cycle completion pulse.
- `mem_rd` out 1: read strobe to the bus.
- `mem_wr` out 1: write strobe to the bus.
- `mem_addr` out ADDR_W: bus address.
- `mem_wdata` out DATA_W: bus write data.
- `mem_rdata` in DATA_W: bus read data (combinational).

## Operation
States: `ARB`, `HOLD`. Owner register: `NONE`, `CPU`, `DMA`.

**Arbitration (`ARB`)**
- Winner is chosen combinationally: `cpu_req = cpu_rd|cpu_wr` wins over `dma_req`, unless the starve guard has fired.
- The winner's address and data drive `mem_*` in the same cycle.
- `MEM_LAT==1`: the access completes in this cycle and the state stays `ARB`.
- `MEM_LAT>1`: latch the owner, set `cnt=MEM_LAT-1`, go to `HOLD`.

**Hold (`HOLD`)**
- The latched owner's live request drives `mem_*`; requesters hold their requests stable.
- `cnt` decrements each cycle. The cycle with `cnt==1` is the completion cycle; next state is `ARB`, owner `NONE`.

**Strobes**
- `mem_rd` is high on every cycle of a read access.
- `mem_wr` is high only in the completion cycle, so exactly one write edge occurs per access.

**Completion**
- CPU owner: `cpu_stall` is low and `cpu_rdata=mem_rdata`.
- DMA owner: `dma_ack=1` and `dma_rdata=mem_rdata`.
- Non-completing cycles: rdata outputs are 0.

**Stall and ack**
- `cpu_stall = cpu_req & ~(owner==CPU & completion)`.
- A DMA-owned access therefore stalls a concurrent CPU request for its full duration.
- `cpu_rd` and `cpu_wr` both high: treated as a write.

## Timing
- Reset, and every cycle `reset` is high (including mid-`HOLD`): state `ARB`, owner `NONE`, `cnt=0`, starve counter 0, all outputs 0, `cpu_stall=0`.
  - An interrupted access is abandoned, with no `mem_wr` and no `dma_ack`.
- Latency from the grant cycle:
  - `MEM_LAT==1`: CPU access completes in the same cycle, zero stall.
  - Otherwise: `MEM_LAT` cycles, with `cpu_stall` high for the first `MEM_LAT-1`.
- Back-to-back: a new grant is possible in the cycle after completion. No idle bubble is required beyond returning to `ARB`.
- `dma_ack` is never high on two consecutive cycles for one request. The DMA deasserts or changes `dma_req` after seeing the ack.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - A starve counter increments on each `ARB` cycle where `dma_req` is high and the DMA loses.
  - When the counter equals `STARVE_MAX`, the next `ARB` decision grants the DMA even if `cpu_req` is high.
  - The counter clears on any DMA grant and saturates at `STARVE_MAX`.
- `DMEM_ARB_STARVE_GUARD_EN` undefined: strict CPU priority. The counter is absent and the DMA may starve indefinitely.

## Structure
- Package `dmem_arb_pkg`:
  - state enum (`ARB`, `HOLD`);
  - owner enum (`NONE`, `CPU`, `DMA`);
  - default `MEM_LAT` and `STARVE_MAX` constants.
- One sub-module, `arb_starve_ctr`: saturating counter with inputs `inc`, `clr` and output `fire`. It is instantiated only under the macro.

## Test plan
- **CPU only:** `MEM_LAT=1`, `cpu_rd` at 0x10 with `mem_rdata`=0xDEADBEEF -> same-cycle `cpu_rdata`=0xDEADBEEF, `cpu_stall`=0 throughout.
- **Collision:** `MEM_LAT=3`, `cpu_wr` and `dma_req` both raised -> CPU granted with stall high 2 cycles and one `mem_wr` pulse on cycle 3. DMA is granted next and `dma_ack` pulses 3 cycles later.
- **DMA owns memory:** DMA read in `HOLD` when `cpu_rd` arrives -> `cpu_stall` high until the DMA completes, then the CPU completes `MEM_LAT` cycles after its grant.
- **Starvation (guard on):** `STARVE_MAX=4`, continuous `cpu_rd` plus `dma_req` -> DMA loses 4 arbitrations and is granted on the 5th. A guard-off build never acks the DMA.
- **Reset mid-access:** `reset` asserted on cycle 2 of a 3-cycle DMA write -> no `mem_wr` and no `dma_ack`. All outputs are 0 the next cycle, and a fresh CPU access then completes normally.
